// File: rtl/rr_mux_arbiter_if.sv
// Bus bundle between the round-robin arbiter and its requesters / downstream 16:1 mux.
interface rr_mux_arbiter_if;
  localparam int unsigned NREQ = 16;
  localparam int unsigned SELW = 4;

  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] a;
  logic [SELW-1:0] sel;
  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  logic            mux_out;
  logic            timeout;

  modport master (
    output req, done, a,
    input  sel, gnt, gnt_valid, mux_out, timeout
  );

  modport slave (
    input  req, done, a,
    output sel, gnt, gnt_valid, mux_out, timeout
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning the select of a shared 16:1 bit mux.
// Optional hold limit with forced release is enabled by macro ARB_TIMEOUT_EN.
module rr_mux_arbiter
`ifdef ARB_TIMEOUT_EN
  #(parameter int unsigned MAX_HOLD = 8)
`endif
  (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux_arbiter_if.slave  bus
  );

  localparam int unsigned NREQ  = 16;
  localparam int unsigned SELW  = 4;
  localparam int unsigned HOLDW = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] sel_q;
  logic [NREQ-1:0] gnt_q;
  logic            gv_q;
  logic [SELW-1:0] win_c;
  logic            win_found_c;
  logic            release_c;
`ifdef ARB_TIMEOUT_EN
  logic [HOLDW-1:0] hold_cnt;
  logic             to_q;
  logic             force_c;
`endif

  // First asserted request scanning upward from ptr with wrap.
  always_comb begin : winner_search
    logic [SELW-1:0] idx;
    idx         = '0;
    win_c       = '0;
    win_found_c = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = ptr + SELW'(i);
      if (!win_found_c && bus.req[idx]) begin
        win_c       = idx;
        win_found_c = 1'b1;
      end
    end
  end

  // Done wins over a same-cycle hold limit, so force only fires without done.
  always_comb begin
`ifdef ARB_TIMEOUT_EN
    force_c   = ~bus.done & (hold_cnt == HOLDW'(MAX_HOLD));
    release_c = bus.done | ~bus.req[sel_q] | force_c;
`else
    release_c = bus.done | ~bus.req[sel_q];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      sel_q <= '0;
      gnt_q <= '0;
      gv_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      to_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_found_c) begin
            sel_q <= win_c;
            gnt_q <= NREQ'(1) << win_c;
            gv_q  <= 1'b1;
            state <= GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= HOLDW'(1);
`endif
          end
        end
        GRANT: begin
          if (release_c) begin
            gnt_q <= '0;
            gv_q  <= 1'b0;
            ptr   <= sel_q + SELW'(1);
            state <= IDLE;
`ifdef ARB_TIMEOUT_EN
            to_q  <= force_c;
`endif
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_cnt != {HOLDW{1'b1}}) begin
            hold_cnt <= hold_cnt + HOLDW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gv_q;
  assign bus.mux_out   = bus.a[sel_q] & gv_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = to_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed vector table, corner sequences, random vs reference model.
module tb_rr_mux_arbiter;
  localparam int MAXH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_mux_arbiter_if bus();
  rr_mux_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_valid, m_to;
  int m_sel, m_ptr, m_hold;

  typedef struct {
    bit          rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] a;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        gv;
    logic        mux;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(bit rst, logic [15:0] req, logic done, logic [15:0] a,
                              logic [3:0] sel, logic [15:0] gnt, logic gv, logic mux);
    vec_t v;
    v.rst = rst; v.req = req; v.done = done; v.a = a;
    v.sel = sel; v.gnt = gnt; v.gv = gv; v.mux = mux;
    return v;
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0; m_to = 1'b0; m_sel = 0; m_ptr = 0; m_hold = 0;
  endfunction

  function automatic void model_step(logic [15:0] r, logic d);
    bit rel;
    rel  = 1'b0;
    m_to = 1'b0;
    if (!m_valid) begin
      for (int k = 0; k < 16; k++) begin
        int idx;
        idx = (m_ptr + k) % 16;
        if (r[idx]) begin
          m_sel = idx; m_valid = 1'b1; m_hold = 1;
          break;
        end
      end
    end else begin
      if (d) rel = 1'b1;
`ifdef ARB_TIMEOUT_EN
      else if (m_hold == MAXH) begin rel = 1'b1; m_to = 1'b1; end
`endif
      else if (!r[m_sel]) rel = 1'b1;
      if (rel) begin
        m_valid = 1'b0;
        m_ptr   = (m_sel + 1) % 16;
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end
  endfunction

  function automatic logic [22:0] dut_out();
    return {bus.sel, bus.gnt, bus.gnt_valid, bus.timeout, bus.mux_out};
  endfunction

  function automatic logic [22:0] model_out();
    logic [15:0] g;
    logic        mx;
    g  = m_valid ? (16'd1 << m_sel) : 16'd0;
    mx = m_valid ? bus.a[m_sel] : 1'b0;
    return {4'(m_sel), g, 1'(m_valid), 1'(m_to), mx};
  endfunction

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got sel=%0d gnt=%h gv=%b to=%b mux=%b, want sel=%0d gnt=%h gv=%b to=%b mux=%b",
               name, act[22:19], act[18:3], act[2], act[1], act[0],
               exp[22:19], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Called at a falling edge; drives inputs, steps across one rising edge, returns at next falling edge.
  task automatic apply(input logic [15:0] r, input logic d, input logic [15:0] av);
    bus.req = r; bus.done = d; bus.a = av;
    @(posedge clk);
    if (rst_n) model_step(r, d);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [15:0] r);
    rst_n = 1'b0;
    bus.req = r; bus.done = 1'b0; bus.a = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("reset", dut_out(), 23'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic        d;
    vec_t        v;

    bus.req = '0; bus.done = 1'b0; bus.a = '0;
    rst_n = 1'b0;
    model_reset();

    // Reset with all requests pending, then first grant goes to requester 0
    do_reset(16'hFFFF);
    apply(16'hFFFF, 1'b0, 16'h0001);
    check("first_grant", dut_out(), {4'd0, 16'h0001, 1'b1, 1'b0, 1'b1});
    check("first_grant_model", dut_out(), model_out());

    // rotation, wrap/skip, abandon, done-while-idle
    tab.push_back(mk(1, 16'h8001, 0, 16'h0001,  0, 16'h0001, 1, 1));
    tab.push_back(mk(0, 16'h8001, 1, 16'h0001,  0, 16'h0000, 0, 0));
    tab.push_back(mk(0, 16'h8001, 0, 16'h0001, 15, 16'h8000, 1, 0));
    tab.push_back(mk(0, 16'h8001, 1, 16'h8000, 15, 16'h0000, 0, 0));
    tab.push_back(mk(0, 16'h8001, 0, 16'h8000,  0, 16'h0001, 1, 0));
    tab.push_back(mk(0, 16'h8001, 1, 16'h8000,  0, 16'h0000, 0, 0));
    tab.push_back(mk(0, 16'h8001, 0, 16'h8000, 15, 16'h8000, 1, 1));
    tab.push_back(mk(0, 16'h8001, 1, 16'h8000, 15, 16'h0000, 0, 0));
    tab.push_back(mk(1, 16'h2000, 0, 16'h2000, 13, 16'h2000, 1, 1));
    tab.push_back(mk(0, 16'h2000, 1, 16'h0000, 13, 16'h0000, 0, 0));
    tab.push_back(mk(0, 16'h0024, 0, 16'h0004,  2, 16'h0004, 1, 1));
    tab.push_back(mk(0, 16'h0024, 1, 16'h0000,  2, 16'h0000, 0, 0));
    tab.push_back(mk(0, 16'h0024, 0, 16'h0020,  5, 16'h0020, 1, 1));
    tab.push_back(mk(0, 16'h0080, 0, 16'hFFFF,  5, 16'h0000, 0, 0));
    tab.push_back(mk(0, 16'h0080, 0, 16'h0080,  7, 16'h0080, 1, 1));
    tab.push_back(mk(0, 16'h0080, 0, 16'h0000,  7, 16'h0080, 1, 0));
    tab.push_back(mk(0, 16'h0180, 0, 16'h0080,  7, 16'h0080, 1, 1));
    tab.push_back(mk(0, 16'h0000, 0, 16'hFFFF,  7, 16'h0000, 0, 0));
    tab.push_back(mk(0, 16'h0000, 1, 16'hFFFF,  7, 16'h0000, 0, 0));
    tab.push_back(mk(0, 16'h0100, 0, 16'h0100,  8, 16'h0100, 1, 1));

    foreach (tab[i]) begin
      v = tab[i];
      if (v.rst) do_reset(16'h0000);
      apply(v.req, v.done, v.a);
      check($sformatf("vec%0d", i), dut_out(), {v.sel, v.gnt, v.gv, 1'b0, v.mux});
      check($sformatf("vec%0d_model", i), dut_out(), model_out());
    end

    // Async reset between edges while requester 9 owns the mux
    do_reset(16'h0000);
    apply(16'h0200, 1'b0, 16'h0200);
    check("pre_async", dut_out(), {4'd9, 16'h0200, 1'b1, 1'b0, 1'b1});
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("async_rst", dut_out(), 23'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(16'h0200, 1'b0, 16'h0000);
    check("post_async", dut_out(), {4'd9, 16'h0200, 1'b1, 1'b0, 1'b0});

`ifdef ARB_TIMEOUT_EN
    // Forced release after MAX_HOLD cycles, then done on the limit edge suppresses the pulse
    do_reset(16'h0000);
    apply(16'h0008, 1'b0, 16'h0008);
    check("to_grant", dut_out(), {4'd3, 16'h0008, 1'b1, 1'b0, 1'b1});
    for (int k = 1; k < MAXH; k++) begin
      apply(16'h0008, 1'b0, 16'h0008);
      check($sformatf("to_hold%0d", k), dut_out(), {4'd3, 16'h0008, 1'b1, 1'b0, 1'b1});
    end
    apply(16'h0008, 1'b0, 16'h0008);
    check("to_pulse", dut_out(), {4'd3, 16'h0000, 1'b0, 1'b1, 1'b0});
    apply(16'h0008, 1'b0, 16'h0008);
    check("to_regrant", dut_out(), {4'd3, 16'h0008, 1'b1, 1'b0, 1'b1});
    for (int k = 1; k < MAXH; k++) apply(16'h0008, 1'b0, 16'h0008);
    apply(16'h0008, 1'b1, 16'h0008);
    check("to_done_wins", dut_out(), {4'd3, 16'h0000, 1'b0, 1'b0, 1'b0});
`else
    // Without the hold limit a grant persists indefinitely
    do_reset(16'h0000);
    apply(16'h0008, 1'b0, 16'h0008);
    for (int k = 0; k < 3 * MAXH; k++) apply(16'h0008, 1'b0, 16'h0008);
    check("no_limit", dut_out(), {4'd3, 16'h0008, 1'b1, 1'b0, 1'b1});
`endif

    // Randomised traffic against the reference model
    do_reset(16'h0000);
    r = 16'h0000;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0:       r = 16'($urandom);
        1:       r = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2:       r = 16'd1 << $urandom_range(0, 15);
        3:       r = 16'h0000;
        default: ;
      endcase
      d = ($urandom_range(0, 5) == 0);
      apply(r, d, 16'($urandom));
      check("rand", dut_out(), model_out());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
